epp_slave: RTL

- Host-side bridge for the Digilent EPP-style USB parallel port: usb_astb, usb_dstb, usb_write, usb_db, usb_wait.
- Sits directly upstream of machine.
- Decodes host address and data strobe cycles into a single-cycle register-bus protocol, and drives the usb_wait handshake.
- The top level owns the usb_db tristate; this block exposes separate in/out/oe signals.

---
 rtl/epp_slave_pkg.sv | 23 ++
 rtl/epp_sync.sv | 31 +++
 rtl/epp_slave.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/epp_slave_pkg.sv
// Shared definitions for the EPP host bridge: FSM states, bus direction
// encoding and the address auto-increment helper.
package epp_slave_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_AWR     = 3'd1,
    ST_ARD     = 3'd2,
    ST_DWR     = 3'd3,
    ST_DRD_REQ = 3'd4,
    ST_DRD_CAP = 3'd5,
    ST_ACK     = 3'd6
  } epp_state_e;

  localparam logic EPP_DIR_WRITE = 1'b0;
  localparam logic EPP_DIR_READ  = 1'b1;

  // Wraps naturally from 8'hFF to 8'h00.
  function automatic logic [7:0] epp_addr_inc(input logic [7:0] addr);
    return addr + 8'd1;
  endfunction

endpackage

// File: rtl/epp_sync.sv
// Multi-stage synchroniser with asynchronous active-low reset to a
// per-bit idle value.
module epp_sync #(
  parameter int unsigned       WIDTH     = 1,
  parameter int unsigned       STAGES    = 2,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        stage_q[i] <= RESET_VAL;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int unsigned i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/epp_slave.sv
// EPP host-port slave: turns synchronised address/data strobe cycles into a
// single-cycle register bus and drives the usb_wait handshake.
// Optional build macro EPP_AUTOINC_EN: post-increment reg_addr after every data cycle.
module epp_slave
  import epp_slave_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  ADDR_RESET  = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       usb_astb,
  input  logic       usb_dstb,
  input  logic       usb_write,
  input  logic [7:0] usb_db_i,
  output logic [7:0] usb_db_o,
  output logic       usb_db_oe,
  output logic       usb_wait,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata
);

  logic       astb_s;
  logic       dstb_s;
  logic       write_s;
  logic [7:0] db_s;

  // Strobes idle high; direction bit idles at host-write.
  epp_sync #(
    .WIDTH     (3),
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (3'b110)
  ) u_sync_ctrl (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   ({usb_astb, usb_dstb, usb_write}),
    .q_o   ({astb_s, dstb_s, write_s})
  );

  epp_sync #(
    .WIDTH     (8),
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (8'h00)
  ) u_sync_db (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (usb_db_i),
    .q_o   (db_s)
  );

  epp_state_e state_q;
  logic [7:0] addr_q;
  logic [7:0] wdata_q;
  logic [7:0] dbo_q;
  logic       oe_q;
  logic       wait_q;
  logic       we_q;
  logic       re_q;
  logic [7:0] addr_ack_d;

`ifdef EPP_AUTOINC_EN
  logic data_cyc_q;

  // Remembers whether the cycle now in ACK was a data cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_cyc_q <= 1'b0;
    end else if (state_q == ST_IDLE) begin
      data_cyc_q <= astb_s && !dstb_s;
    end
  end

  always_comb begin
    addr_ack_d = addr_q;
    if (data_cyc_q) begin
      addr_ack_d = epp_addr_inc(addr_q);
    end
  end
`else
  always_comb begin
    addr_ack_d = addr_q;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= ADDR_RESET;
      wdata_q <= '0;
      dbo_q   <= '0;
      oe_q    <= 1'b0;
      wait_q  <= 1'b0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
    end else begin
      we_q <= 1'b0;
      re_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // Address strobe has priority; direction is latched here.
          if (!astb_s) begin
            state_q <= (write_s == EPP_DIR_READ) ? ST_ARD : ST_AWR;
          end else if (!dstb_s) begin
            if (write_s == EPP_DIR_READ) begin
              state_q <= ST_DRD_REQ;
              re_q    <= 1'b1;
            end else begin
              state_q <= ST_DWR;
              we_q    <= 1'b1;
              wdata_q <= db_s;
            end
          end
        end
        ST_AWR: begin
          addr_q  <= db_s;
          wait_q  <= 1'b1;
          state_q <= ST_ACK;
        end
        ST_ARD: begin
          dbo_q   <= addr_q;
          oe_q    <= 1'b1;
          wait_q  <= 1'b1;
          state_q <= ST_ACK;
        end
        ST_DWR: begin
          wait_q  <= 1'b1;
          state_q <= ST_ACK;
        end
        ST_DRD_REQ: begin
          state_q <= ST_DRD_CAP;
        end
        ST_DRD_CAP: begin
          dbo_q   <= reg_rdata;
          oe_q    <= 1'b1;
          wait_q  <= 1'b1;
          state_q <= ST_ACK;
        end
        ST_ACK: begin
          if (astb_s && dstb_s) begin
            wait_q  <= 1'b0;
            oe_q    <= 1'b0;
            addr_q  <= addr_ack_d;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign usb_db_o  = dbo_q;
  assign usb_db_oe = oe_q;
  assign usb_wait  = wait_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_we    = we_q;
  assign reg_re    = re_q;

endmodule
